// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational Alu among NUM_REQ requesters.
// The granted request drives the Alu; its result is captured, tagged with the
// requester ID, into a 2-entry FIFO drained over a single response channel.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OPER_WIDTH = 4,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*OPER_WIDTH-1:0]  req_oper_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_i,
  output logic [OPER_WIDTH-1:0]          alu_oper_o,
  output logic [DATA_WIDTH-1:0]          alu_a_o,
  output logic [DATA_WIDTH-1:0]          alu_b_o,
  input  logic [DATA_WIDTH-1:0]          alu_data_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ID_WIDTH-1:0]            rsp_id_o,
  output logic [DATA_WIDTH-1:0]          rsp_data_o,
  output logic                           busy_o
);

  // Round-robin pointer: the requester searched first on the next grant.
  logic [ID_WIDTH-1:0]   rr_q, rr_d;

  // Two-entry FIFO storage and bookkeeping.
  logic [ID_WIDTH-1:0]   mem_id_q   [2];
  logic [DATA_WIDTH-1:0] mem_data_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;

  logic [ID_WIDTH-1:0]   gnt_id;
  logic                  has_gnt;
  logic                  space;
  logic                  push, pop;
  int unsigned           idx;

  // Grant search: first valid requester at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_id  = '0;
    has_gnt = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!has_gnt && req_valid_i[idx]) begin
        has_gnt = 1'b1;
        gnt_id  = ID_WIDTH'(idx);
      end
    end
  end

  // Alu drive: granted operands, or all-zero when idle to avoid toggling.
  always_comb begin
    alu_oper_o = '0;
    alu_a_o    = '0;
    alu_b_o    = '0;
    if (has_gnt) begin
      alu_oper_o = req_oper_i[gnt_id*OPER_WIDTH +: OPER_WIDTH];
      alu_a_o    = req_a_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      alu_b_o    = req_b_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Handshake: a pop while full frees a slot for a same-cycle push.
  always_comb begin
    rsp_valid_o = (count_q != 2'd0);
    pop         = rsp_valid_o & rsp_ready_i;
    space       = (count_q < 2'd2) | pop;
    push        = has_gnt & space;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = push & (gnt_id == ID_WIDTH'(i));
    end
    rsp_id_o   = mem_id_q[rd_ptr_q];
    rsp_data_o = mem_data_q[rd_ptr_q];
    busy_o     = rsp_valid_o | (|req_valid_i);
  end

  // Next-state for occupancy and round-robin pointer.
  always_comb begin
    count_d = count_q;
    rr_d    = rr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push) begin
      rr_d = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + ID_WIDTH'(1);
    end
  end

  // State registers; reset discards any queued responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_id_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      count_q <= count_d;
      if (push) begin
        mem_id_q[wr_ptr_q]   <= gnt_id;
        mem_data_q[wr_ptr_q] <= alu_data_i;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Occupancy must stay within 0..2.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push && !pop && count_q == 2'd2)) else $error("fifo overflow");
      assert (!(pop && count_q == 2'd0)) else $error("fifo underflow");
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural Alu model.
module tb_alu_share_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;
  localparam int unsigned IW = 2;

  // Opcode encoding is private to the bench Alu model; the arbiter passes it through.
  localparam logic [OW-1:0] OpAdd = 4'd0;
  localparam logic [OW-1:0] OpSub = 4'd1;
  localparam logic [OW-1:0] OpAsr = 4'd2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*OW-1:0]  req_oper;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [OW-1:0]     alu_oper;
  logic [DW-1:0]     alu_a, alu_b, alu_data;
  logic              rsp_valid, rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  logic [OW-1:0] op [NR];
  logic [DW-1:0] a  [NR];
  logic [DW-1:0] b  [NR];

  int n_chk  = 0;
  int n_pass = 0;

  assign req_oper = {op[2], op[1], op[0]};
  assign req_a    = {a[2], a[1], a[0]};
  assign req_b    = {b[2], b[1], b[0]};

  always #5 clk_i = ~clk_i;

  // Alu model: shift amounts of DW or more fill with the sign bit.
  always_comb begin
    alu_data = '0;
    case (alu_oper)
      OpAdd:   alu_data = alu_a + alu_b;
      OpSub:   alu_data = alu_a - alu_b;
      OpAsr:   alu_data = (alu_b >= 32'd32) ? {DW{alu_a[DW-1]}}
                                           : DW'($signed(alu_a) >>> alu_b[4:0]);
      default: alu_data = '0;
    endcase
  end

  alu_share_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .OPER_WIDTH(OW),
    .ID_WIDTH  (IW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_oper_i (req_oper),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .alu_oper_o (alu_oper),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_data_i (alu_data),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_id_o   (rsp_id),
    .rsp_data_o (rsp_data),
    .busy_o     (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_ni    = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      op[i] = OpAdd;
      a[i]  = '0;
      b[i]  = '0;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_ni    = 1'b0;
    #2;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id",    64'(rsp_id),    64'd0);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single request: 5 + 7 from requester 0.
    op[0] = OpAdd; a[0] = 32'd5; b[0] = 32'd7;
    req_valid = 3'b001;
    rsp_ready = 1'b1;
    #1;
    check("single_ready", 64'(req_ready), 64'b001);
    check("single_alu_a", 64'(alu_a), 64'd5);
    tick();
    req_valid = 3'b000;
    #1;
    check("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check("single_rsp_id",    64'(rsp_id),    64'd0);
    check("single_rsp_data",  64'(rsp_data),  64'd12);
    tick();
    check("single_empty", 64'(rsp_valid), 64'd0);
    check("single_idle",  64'(busy),      64'd0);

    // Round-robin: every requester issues 100 - i continuously.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      op[i] = OpSub; a[i] = 32'd100; b[i] = 32'(i);
    end
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
      if (k > 0) begin
        check("rr_rsp_id",   64'(rsp_id),   64'((k - 1) % 3));
        check("rr_rsp_data", 64'(rsp_data), 64'(100 - ((k - 1) % 3)));
      end
      tick();
    end
    req_valid = 3'b000;
    #1;
    check("rr_last_id",   64'(rsp_id),   64'd2);
    check("rr_last_data", 64'(rsp_data), 64'd98);
    tick();
    check("rr_drained", 64'(rsp_valid), 64'd0);

    // Backpressure: two accepts fill the FIFO, then grants stall.
    op[0] = OpAdd; a[0] = 32'd1; b[0] = 32'd1;
    op[1] = OpAdd; a[1] = 32'd2; b[1] = 32'd2;
    rsp_ready = 1'b0;
    req_valid = 3'b011;
    #1;
    check("bp_grant0", 64'(req_ready), 64'b001);
    tick();
    check("bp_grant1", 64'(req_ready), 64'b010);
    check("bp_head0",  64'(rsp_id),    64'd0);
    tick();
    check("bp_full_stall", 64'(req_ready), 64'b000);
    check("bp_busy",       64'(busy),      64'd1);
    tick();
    check("bp_still_stall", 64'(req_ready), 64'b000);
    // Pointer held at 2, so the search wraps to requester 0 once space appears.
    rsp_ready = 1'b1;
    #1;
    check("bp_pop_push_grant", 64'(req_ready), 64'b001);
    check("bp_pop_data",       64'(rsp_data),  64'd2);
    tick();
    rsp_ready = 1'b0;
    #1;
    check("bp_next_id",   64'(rsp_id),    64'd1);
    check("bp_next_data", 64'(rsp_data),  64'd4);
    check("bp_full_again", 64'(req_ready), 64'b000);

    // Drop before grant: requester 1 withdraws while the FIFO is full.
    op[2] = OpAdd; a[2] = 32'd10; b[2] = 32'd20;
    req_valid = 3'b110;
    #1;
    check("drop_blocked", 64'(req_ready), 64'b000);
    tick();
    req_valid = 3'b100;
    rsp_ready = 1'b1;
    #1;
    check("drop_serve2", 64'(req_ready), 64'b100);
    check("drop_head_id", 64'(rsp_id),   64'd1);
    tick();
    req_valid = 3'b000;
    #1;
    check("drop_rsp_id_a",   64'(rsp_id),   64'd0);
    check("drop_rsp_data_a", 64'(rsp_data), 64'd2);
    tick();
    check("drop_rsp_id_b",   64'(rsp_id),   64'd2);
    check("drop_rsp_data_b", 64'(rsp_data), 64'd30);
    tick();
    check("drop_drained", 64'(rsp_valid), 64'd0);

    // Shift passthrough: oversized arithmetic shift of a negative value.
    op[2] = OpAsr; a[2] = 32'h8000_0000; b[2] = 32'd40;
    req_valid = 3'b100;
    #1;
    check("asr_grant", 64'(req_ready), 64'b100);
    check("asr_oper",  64'(alu_oper),  64'(OpAsr));
    tick();
    req_valid = 3'b000;
    #1;
    check("asr_rsp_id",   64'(rsp_id),   64'd2);
    check("asr_rsp_data", 64'(rsp_data), 64'hFFFF_FFFF);
    tick();

    // Asynchronous reset with two entries queued.
    rsp_ready = 1'b0;
    op[0] = OpAdd; a[0] = 32'd3; b[0] = 32'd4;
    op[1] = OpAdd; a[1] = 32'd5; b[1] = 32'd6;
    req_valid = 3'b011;
    tick();
    tick();
    req_valid = 3'b000;
    #1;
    check("ar_queued", 64'(rsp_valid), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("ar_rsp_valid", 64'(rsp_valid), 64'd0);
    check("ar_busy",      64'(busy),      64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_valid = 3'b111;
    #1;
    check("ar_first_grant", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b000;
    #1;
    check("ar_rsp_id",   64'(rsp_id),   64'd0);
    check("ar_rsp_data", 64'(rsp_data), 64'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
